// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: datapath defaults, base opcodes and immediate formats.
package rv32_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // R-type and unrecognised opcodes carry no immediate.
  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OP_LOAD, OP_OPIMM, OP_JALR: fmt = IMM_I;
      OP_STORE:                   fmt = IMM_S;
      OP_BRANCH:                  fmt = IMM_B;
      OP_LUI, OP_AUIPC:           fmt = IMM_U;
      OP_JAL:                     fmt = IMM_J;
      default:                    fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_imm_gen.sv
// Combinational immediate generator: extracts and sign-extends the I/S/B/U/J
// immediate selected by the opcode.
module imm_gen #(
  parameter int XLEN = rv32_pkg::XLEN
) (
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm
);
  import rv32_pkg::*;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    imm = '0;
    case (imm_fmt_of(instr[6:0]))
      IMM_I: imm = {{(XLEN-11){instr[31]}}, instr[30:20]};
      IMM_S: imm = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
      IMM_J: imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID-side operand stage: register-file addressing, WB bypass, x0 forcing,
// load-use bubble insertion and the ID/EX pipeline register.
module id_ex_operand_stage #(
  parameter int XLEN      = rv32_pkg::XLEN,
  parameter int RADDR_W   = rv32_pkg::RADDR_W,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               ID_VALID,
  input  logic [XLEN-1:0]    ID_INSTR,
  input  logic [XLEN-1:0]    ID_PC,
  output logic [RADDR_W-1:0] RF_ADDR1,
  output logic [RADDR_W-1:0] RF_ADDR2,
  input  logic [XLEN-1:0]    RF_DATA1,
  input  logic [XLEN-1:0]    RF_DATA2,
  input  logic               WB_WRITE,
  input  logic [RADDR_W-1:0] WB_ADDR,
  input  logic [XLEN-1:0]    WB_DATA,
  input  logic               EX_STALL,
  input  logic               FLUSH,
  output logic               ID_STALL,
  output logic               EX_VALID,
  output logic [XLEN-1:0]    EX_PC,
  output logic [XLEN-1:0]    EX_OP1,
  output logic [XLEN-1:0]    EX_OP2,
  output logic [XLEN-1:0]    EX_IMM,
  output logic [XLEN-1:0]    EX_INSTR,
  output logic [RADDR_W-1:0] EX_RD,
  output logic               EX_MEMREAD,
  output logic               EX_REGWRITE
);
  import rv32_pkg::*;

  logic [6:0]         opcode;
  logic [RADDR_W-1:0] rs1;
  logic [RADDR_W-1:0] rs2;
  logic [RADDR_W-1:0] rd;
  logic [XLEN-1:0]    op1;
  logic [XLEN-1:0]    op2;
  logic [XLEN-1:0]    imm;
  logic               uses_rs1;
  logic               uses_rs2;
  logic               is_load;
  logic               writes_rd;
  logic               load_use;

  assign opcode = ID_INSTR[6:0];
  assign rs1    = ID_INSTR[15 +: RADDR_W];
  assign rs2    = ID_INSTR[20 +: RADDR_W];
  assign rd     = ID_INSTR[7 +: RADDR_W];

  assign RF_ADDR1 = rs1;
  assign RF_ADDR2 = rs2;

  // x0 always reads zero; otherwise a same-cycle writeback wins over the
  // stale register-file value.
  function automatic logic [XLEN-1:0] sel_operand(input logic [RADDR_W-1:0] addr,
                                                  input logic [XLEN-1:0]    rf_data);
    logic [XLEN-1:0] val;
    if (addr == '0)
      val = '0;
    else if (BYPASS_EN && WB_WRITE && (WB_ADDR == addr))
      val = WB_DATA;
    else
      val = rf_data;
    return val;
  endfunction

  assign op1 = sel_operand(rs1, RF_DATA1);
  assign op2 = sel_operand(rs2, RF_DATA2);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (ID_INSTR),
    .imm   (imm)
  );

  always_comb begin
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    is_load   = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        uses_rs1  = 1'b0;
        writes_rd = 1'b1;
      end
      OP_JAL: begin
        uses_rs1  = 1'b0;
        writes_rd = 1'b1;
      end
      OP_OP: begin
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
      OP_LOAD: begin
        is_load   = 1'b1;
        writes_rd = 1'b1;
      end
      OP_OPIMM, OP_JALR: writes_rd = 1'b1;
      default: ;
    endcase
  end

  // A load in EX whose result the ID instruction needs cannot be forwarded in
  // time; hold ID for one cycle and send a bubble instead.
  assign load_use = ID_VALID && EX_VALID && EX_MEMREAD && (EX_RD != '0)
                    && ((uses_rs1 && (rs1 == EX_RD)) || (uses_rs2 && (rs2 == EX_RD)));

  assign ID_STALL = EX_STALL || (load_use && !FLUSH);

  // NOTE: sequential state is assigned with <= only, so every register samples
  // values from before the edge regardless of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      EX_VALID    <= 1'b0;
      EX_PC       <= '0;
      EX_OP1      <= '0;
      EX_OP2      <= '0;
      EX_IMM      <= '0;
      EX_INSTR    <= '0;
      EX_RD       <= '0;
      EX_MEMREAD  <= 1'b0;
      EX_REGWRITE <= 1'b0;
    end else if (FLUSH) begin
      EX_VALID    <= 1'b0;
      EX_MEMREAD  <= 1'b0;
      EX_REGWRITE <= 1'b0;
    end else if (EX_STALL) begin
      EX_VALID    <= EX_VALID;
    end else if (load_use) begin
      EX_VALID    <= 1'b0;
      EX_MEMREAD  <= 1'b0;
      EX_REGWRITE <= 1'b0;
    end else begin
      EX_VALID    <= ID_VALID;
      EX_PC       <= ID_PC;
      EX_OP1      <= op1;
      EX_OP2      <= op2;
      EX_IMM      <= imm;
      EX_INSTR    <= ID_INSTR;
      EX_RD       <= rd;
      EX_MEMREAD  <= ID_VALID && is_load;
      EX_REGWRITE <= ID_VALID && writes_rd && (rd != '0);
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: x0/bypass, load-use bubble,
// flush priority, downstream hold, immediates and asynchronous reset.
module tb_id_ex_operand_stage;

  localparam logic [31:0] I_ADDI_X5_X0_7   = 32'h0070_0293;
  localparam logic [31:0] I_ADD_X3_X1_X2   = 32'h0020_81B3;
  localparam logic [31:0] I_LW_X4_0_X1     = 32'h0000_A203;
  localparam logic [31:0] I_ADD_X6_X4_X4   = 32'h0042_0333;
  localparam logic [31:0] I_ADD_X6_X2_X3   = 32'h0031_0333;
  localparam logic [31:0] I_LUI_X4_20      = 32'h0002_0237;
  localparam logic [31:0] I_LW_X0_0_X1     = 32'h0000_A003;
  localparam logic [31:0] I_ADD_X6_X0_X0   = 32'h0000_0333;
  localparam logic [31:0] I_ADDI_X1_X1_M1  = 32'hFFF0_8093;
  localparam logic [31:0] I_SW_X2_8_X1     = 32'h0020_A423;
  localparam logic [31:0] I_BEQ_X1_X2_M4   = 32'hFE20_8EE3;
  localparam logic [31:0] I_JAL_X1_8       = 32'h0080_00EF;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        ID_VALID;
  logic [31:0] ID_INSTR;
  logic [31:0] ID_PC;
  logic [4:0]  RF_ADDR1;
  logic [4:0]  RF_ADDR2;
  logic [31:0] RF_DATA1;
  logic [31:0] RF_DATA2;
  logic        WB_WRITE;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;
  logic        EX_STALL;
  logic        FLUSH;
  logic        ID_STALL;
  logic        EX_VALID;
  logic [31:0] EX_PC;
  logic [31:0] EX_OP1;
  logic [31:0] EX_OP2;
  logic [31:0] EX_IMM;
  logic [31:0] EX_INSTR;
  logic [4:0]  EX_RD;
  logic        EX_MEMREAD;
  logic        EX_REGWRITE;

  int checks = 0;
  int fails  = 0;

  always #5 CLK = ~CLK;

  id_ex_operand_stage #(.XLEN(32), .RADDR_W(5), .BYPASS_EN(1'b1)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .ID_VALID    (ID_VALID),
    .ID_INSTR    (ID_INSTR),
    .ID_PC       (ID_PC),
    .RF_ADDR1    (RF_ADDR1),
    .RF_ADDR2    (RF_ADDR2),
    .RF_DATA1    (RF_DATA1),
    .RF_DATA2    (RF_DATA2),
    .WB_WRITE    (WB_WRITE),
    .WB_ADDR     (WB_ADDR),
    .WB_DATA     (WB_DATA),
    .EX_STALL    (EX_STALL),
    .FLUSH       (FLUSH),
    .ID_STALL    (ID_STALL),
    .EX_VALID    (EX_VALID),
    .EX_PC       (EX_PC),
    .EX_OP1      (EX_OP1),
    .EX_OP2      (EX_OP2),
    .EX_IMM      (EX_IMM),
    .EX_INSTR    (EX_INSTR),
    .EX_RD       (EX_RD),
    .EX_MEMREAD  (EX_MEMREAD),
    .EX_REGWRITE (EX_REGWRITE)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] rf1, input logic [31:0] rf2);
    ID_VALID = v;
    ID_INSTR = instr;
    ID_PC    = pc;
    RF_DATA1 = rf1;
    RF_DATA2 = rf2;
    #1;
  endtask

  task automatic test_reset();
    RESET_N  = 1'b0;
    ID_VALID = 1'b0; ID_INSTR = '0; ID_PC = '0;
    RF_DATA1 = '0; RF_DATA2 = '0;
    WB_WRITE = 1'b0; WB_ADDR = '0; WB_DATA = '0;
    EX_STALL = 1'b0; FLUSH = 1'b0;
    #2;
    checks++;
    if ({EX_VALID, EX_MEMREAD, EX_REGWRITE, ID_STALL} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0000", {EX_VALID, EX_MEMREAD, EX_REGWRITE, ID_STALL});
    end
    checks++;
    if ((EX_PC | EX_OP1 | EX_OP2 | EX_IMM | EX_INSTR) !== 32'h0 || EX_RD !== 5'd0) begin
      fails++; $display("FAIL reset_data: pc %h op1 %h op2 %h imm %h instr %h rd %0d want all 0",
                        EX_PC, EX_OP1, EX_OP2, EX_IMM, EX_INSTR, EX_RD);
    end
    step(); step();
    RESET_N = 1'b1;
  endtask

  task automatic test_x0_bypass();
    drive_id(1'b1, I_ADDI_X5_X0_7, 32'h100, 32'hDEAD, 32'h0);
    checks++;
    if (RF_ADDR1 !== 5'd0) begin fails++; $display("FAIL rf_addr1_addi: got %0d want 0", RF_ADDR1); end
    step();
    checks++;
    if (EX_OP1 !== 32'h0) begin fails++; $display("FAIL x0_op1: got %h want 0", EX_OP1); end
    checks++;
    if ({EX_VALID, EX_REGWRITE, EX_MEMREAD} !== 3'b110 || EX_RD !== 5'd5 || EX_IMM !== 32'd7 || EX_PC !== 32'h100) begin
      fails++; $display("FAIL addi_fields: v/rw/mr %b rd %0d imm %h pc %h want 110 5 7 100",
                        {EX_VALID, EX_REGWRITE, EX_MEMREAD}, EX_RD, EX_IMM, EX_PC);
    end
    WB_WRITE = 1'b1; WB_ADDR = 5'd1; WB_DATA = 32'd95;
    drive_id(1'b1, I_ADD_X3_X1_X2, 32'h104, 32'd28, 32'd11);
    checks++;
    if (RF_ADDR1 !== 5'd1 || RF_ADDR2 !== 5'd2) begin
      fails++; $display("FAIL rf_addr_add: got %0d,%0d want 1,2", RF_ADDR1, RF_ADDR2);
    end
    step();
    checks++;
    if (EX_OP1 !== 32'd95 || EX_OP2 !== 32'd11 || EX_IMM !== 32'h0) begin
      fails++; $display("FAIL bypass_op: op1 %0d op2 %0d imm %h want 95 11 0", EX_OP1, EX_OP2, EX_IMM);
    end
    WB_ADDR = 5'd2; WB_DATA = 32'd77;
    drive_id(1'b1, I_ADDI_X1_X1_M1, 32'h108, 32'h100, 32'h0);
    step();
    checks++;
    if (EX_OP1 !== 32'h100 || EX_IMM !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL no_bypass_negimm: op1 %h imm %h want 100 ffffffff", EX_OP1, EX_IMM);
    end
    WB_WRITE = 1'b0;
  endtask

  task automatic test_load_use();
    drive_id(1'b1, I_LW_X4_0_X1, 32'h200, 32'h1000, 32'h0);
    step();
    checks++;
    if (EX_MEMREAD !== 1'b1 || EX_RD !== 5'd4) begin
      fails++; $display("FAIL lw_in_ex: memread %b rd %0d want 1 4", EX_MEMREAD, EX_RD);
    end
    drive_id(1'b1, I_ADD_X6_X4_X4, 32'h204, 32'h55, 32'h55);
    checks++;
    if (ID_STALL !== 1'b1) begin fails++; $display("FAIL lu_stall: got %b want 1", ID_STALL); end
    step();
    checks++;
    if ({EX_VALID, EX_MEMREAD, EX_REGWRITE} !== 3'b000) begin
      fails++; $display("FAIL lu_bubble: got %b want 000", {EX_VALID, EX_MEMREAD, EX_REGWRITE});
    end
    WB_WRITE = 1'b1; WB_ADDR = 5'd4; WB_DATA = 32'h77;
    #1;
    checks++;
    if (ID_STALL !== 1'b0) begin fails++; $display("FAIL lu_one_cycle: got %b want 0", ID_STALL); end
    step();
    checks++;
    if (EX_VALID !== 1'b1 || EX_INSTR !== I_ADD_X6_X4_X4 || EX_OP1 !== 32'h77 || EX_OP2 !== 32'h77) begin
      fails++; $display("FAIL lu_after: v %b instr %h op1 %h op2 %h want 1 %h 77 77",
                        EX_VALID, EX_INSTR, EX_OP1, EX_OP2, I_ADD_X6_X4_X4);
    end
    WB_WRITE = 1'b0;
    drive_id(1'b1, I_LW_X4_0_X1, 32'h208, 32'h1000, 32'h0);
    step();
    drive_id(1'b1, I_ADD_X6_X2_X3, 32'h20C, 32'h1, 32'h2);
    checks++;
    if (ID_STALL !== 1'b0) begin fails++; $display("FAIL nostall_add: got %b want 0", ID_STALL); end
    step();
    checks++;
    if (EX_VALID !== 1'b1 || EX_INSTR !== I_ADD_X6_X2_X3) begin
      fails++; $display("FAIL nostall_add_ex: v %b instr %h", EX_VALID, EX_INSTR);
    end
    drive_id(1'b1, I_LW_X4_0_X1, 32'h210, 32'h1000, 32'h0);
    step();
    drive_id(1'b1, I_LUI_X4_20, 32'h214, 32'h9, 32'h9);
    checks++;
    if (ID_STALL !== 1'b0) begin fails++; $display("FAIL nostall_lui: got %b want 0", ID_STALL); end
    step();
    checks++;
    if (EX_VALID !== 1'b1 || EX_IMM !== 32'h0002_0000 || EX_RD !== 5'd4 || EX_REGWRITE !== 1'b1) begin
      fails++; $display("FAIL lui_ex: v %b imm %h rd %0d rw %b want 1 00020000 4 1",
                        EX_VALID, EX_IMM, EX_RD, EX_REGWRITE);
    end
  endtask

  task automatic test_load_x0();
    drive_id(1'b1, I_LW_X0_0_X1, 32'h300, 32'h1000, 32'h0);
    step();
    checks++;
    if (EX_MEMREAD !== 1'b1 || EX_REGWRITE !== 1'b0) begin
      fails++; $display("FAIL lw_x0_ctrl: memread %b regwrite %b want 1 0", EX_MEMREAD, EX_REGWRITE);
    end
    drive_id(1'b1, I_ADD_X6_X0_X0, 32'h304, 32'hAAAA, 32'hBBBB);
    checks++;
    if (ID_STALL !== 1'b0) begin fails++; $display("FAIL lw_x0_stall: got %b want 0", ID_STALL); end
    step();
    checks++;
    if (EX_VALID !== 1'b1 || EX_OP1 !== 32'h0 || EX_OP2 !== 32'h0) begin
      fails++; $display("FAIL lw_x0_ops: v %b op1 %h op2 %h want 1 0 0", EX_VALID, EX_OP1, EX_OP2);
    end
  endtask

  task automatic test_flush_vs_stall();
    drive_id(1'b1, I_LW_X4_0_X1, 32'h400, 32'h1000, 32'h0);
    step();
    FLUSH = 1'b1;
    drive_id(1'b1, I_ADD_X6_X4_X4, 32'h404, 32'h3, 32'h3);
    checks++;
    if (ID_STALL !== 1'b0) begin fails++; $display("FAIL flush_masks_lu: got %b want 0", ID_STALL); end
    EX_STALL = 1'b1;
    step();
    checks++;
    if ({EX_VALID, EX_MEMREAD, EX_REGWRITE} !== 3'b000) begin
      fails++; $display("FAIL flush_over_stall: got %b want 000", {EX_VALID, EX_MEMREAD, EX_REGWRITE});
    end
    FLUSH = 1'b0; EX_STALL = 1'b0;
    #1;
    step();
    checks++;
    if (EX_VALID !== 1'b1 || EX_INSTR !== I_ADD_X6_X4_X4 || EX_PC !== 32'h404) begin
      fails++; $display("FAIL after_flush: v %b instr %h pc %h", EX_VALID, EX_INSTR, EX_PC);
    end
  endtask

  task automatic test_hold();
    logic [31:0] hold_instr [3];
    hold_instr[0] = I_ADD_X3_X1_X2;
    hold_instr[1] = I_SW_X2_8_X1;
    hold_instr[2] = I_LW_X4_0_X1;
    drive_id(1'b1, I_ADDI_X1_X1_M1, 32'h500, 32'h100, 32'h0);
    step();
    EX_STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, hold_instr[i], 32'h504 + 32'(4 * i), 32'h900 + 32'(i), 32'h0);
      checks++;
      if (ID_STALL !== 1'b1) begin fails++; $display("FAIL hold_stall_%0d: got %b want 1", i, ID_STALL); end
      step();
      checks++;
      if (EX_VALID !== 1'b1 || EX_INSTR !== I_ADDI_X1_X1_M1 || EX_OP1 !== 32'h100 || EX_PC !== 32'h500) begin
        fails++; $display("FAIL hold_ex_%0d: v %b instr %h op1 %h pc %h", i, EX_VALID, EX_INSTR, EX_OP1, EX_PC);
      end
    end
    EX_STALL = 1'b0;
    drive_id(1'b1, I_BEQ_X1_X2_M4, 32'h520, 32'd5, 32'd6);
    step();
    checks++;
    if (EX_INSTR !== I_BEQ_X1_X2_M4 || EX_IMM !== 32'hFFFF_FFFC || EX_REGWRITE !== 1'b0 || EX_OP2 !== 32'd6) begin
      fails++; $display("FAIL release_beq: instr %h imm %h rw %b op2 %0d want %h fffffffc 0 6",
                        EX_INSTR, EX_IMM, EX_REGWRITE, EX_OP2, I_BEQ_X1_X2_M4);
    end
    drive_id(1'b1, I_SW_X2_8_X1, 32'h524, 32'd5, 32'd6);
    step();
    checks++;
    if (EX_IMM !== 32'd8 || EX_REGWRITE !== 1'b0 || EX_MEMREAD !== 1'b0) begin
      fails++; $display("FAIL sw_imm: imm %h rw %b mr %b want 8 0 0", EX_IMM, EX_REGWRITE, EX_MEMREAD);
    end
    drive_id(1'b1, I_JAL_X1_8, 32'h528, 32'd0, 32'd0);
    step();
    checks++;
    if (EX_IMM !== 32'd8 || EX_REGWRITE !== 1'b1 || EX_RD !== 5'd1) begin
      fails++; $display("FAIL jal_imm: imm %h rw %b rd %0d want 8 1 1", EX_IMM, EX_REGWRITE, EX_RD);
    end
    drive_id(1'b0, I_ADDI_X5_X0_7, 32'h52C, 32'd0, 32'd0);
    step();
    checks++;
    if ({EX_VALID, EX_REGWRITE, EX_MEMREAD} !== 3'b000) begin
      fails++; $display("FAIL invalid_gate: got %b want 000", {EX_VALID, EX_REGWRITE, EX_MEMREAD});
    end
  endtask

  task automatic test_async_reset();
    drive_id(1'b1, I_JAL_X1_8, 32'h600, 32'd0, 32'd0);
    step();
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({EX_VALID, EX_REGWRITE, EX_MEMREAD} !== 3'b000 || EX_PC !== 32'h0 || EX_IMM !== 32'h0
        || EX_INSTR !== 32'h0 || EX_RD !== 5'd0 || EX_OP1 !== 32'h0 || EX_OP2 !== 32'h0) begin
      fails++; $display("FAIL async_reset: v %b pc %h imm %h instr %h rd %0d",
                        EX_VALID, EX_PC, EX_IMM, EX_INSTR, EX_RD);
    end
    step();
    drive_id(1'b1, I_ADDI_X5_X0_7, 32'h700, 32'd0, 32'd0);
    #2;
    RESET_N = 1'b1;
    step();
    checks++;
    if (EX_VALID !== 1'b1 || EX_INSTR !== I_ADDI_X5_X0_7 || EX_PC !== 32'h700) begin
      fails++; $display("FAIL post_reset_first: v %b instr %h pc %h", EX_VALID, EX_INSTR, EX_PC);
    end
  endtask

  initial begin
    test_reset();
    test_x0_bypass();
    test_load_use();
    test_load_x0();
    test_flush_vs_stall();
    test_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
